// File: rtl/mips_cpu_fetch_unit_if.sv
// Fetch-unit bus: instruction port, decode-stage latch outputs and decode
// back-pressure/redirect inputs.
interface mips_cpu_fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fd_valid;

  modport master (
    input  stall, redirect_valid, redirect_target, instr_readdata,
    output instr_address, fd_instr, fd_pc, fd_valid
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instr_readdata,
    input  instr_address, fd_instr, fd_pc, fd_valid
  );
endinterface

// File: rtl/mips_cpu_fetch_unit.sv
// Instruction-fetch front end: PC, fetch/decode latch, delay-slot redirects, halt.
// Optional FETCH_INSTR_COUNT_EN adds a saturating instr_count output.
module mips_cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  mips_cpu_fetch_unit_if.master    bus,
  output logic                     active,
  output logic                     addr_error
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0]              instr_count
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pending_target, pending_target_next;
  logic [31:0] fd_instr_next, fd_pc_next;
  logic        fd_valid_next, active_next, addr_error_next;
  logic        load_fd;
  logic [31:0] target;
  logic        target_valid;

  assign bus.instr_address = pc;

  always_comb begin
    state_next          = state;
    pc_next             = pc;
    pending_target_next = pending_target;
    fd_instr_next       = bus.fd_instr;
    fd_pc_next          = bus.fd_pc;
    fd_valid_next       = bus.fd_valid;
    active_next         = active;
    addr_error_next     = addr_error;
    load_fd             = 1'b0;
    target              = pc + 32'd4;
    target_valid        = 1'b0;

    // RUN takes a live redirect; PENDING replays the captured one on release.
    if (state == RUN && bus.redirect_valid) begin
      target       = bus.redirect_target;
      target_valid = 1'b1;
    end else if (state == PENDING) begin
      target       = pending_target;
      target_valid = 1'b1;
    end

    case (state)
      RUN, PENDING: begin
        if (bus.stall) begin
          if (state == RUN && bus.redirect_valid) begin
            pending_target_next = bus.redirect_target;
            state_next          = PENDING;
          end
        end else if (pc == HALT_ADDR) begin
          state_next    = HALTED;
          fd_valid_next = 1'b0;
          active_next   = 1'b0;
        end else begin
          load_fd       = 1'b1;
          fd_instr_next = bus.instr_readdata;
          fd_pc_next    = pc;
          fd_valid_next = 1'b1;
          if (target_valid && target[1:0] != 2'b00) begin
            addr_error_next = 1'b1;
            active_next     = 1'b0;
            pc_next         = HALT_ADDR;
            state_next      = HALTED;
          end else begin
            pc_next    = target;
            state_next = RUN;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= '0;
      bus.fd_instr   <= '0;
      bus.fd_pc      <= '0;
      bus.fd_valid   <= 1'b0;
      active         <= 1'b1;
      addr_error     <= 1'b0;
    end else if (clk_enable) begin
      state          <= state_next;
      pc             <= pc_next;
      pending_target <= pending_target_next;
      bus.fd_instr   <= fd_instr_next;
      bus.fd_pc      <= fd_pc_next;
      bus.fd_valid   <= fd_valid_next;
      active         <= active_next;
      addr_error     <= addr_error_next;
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
    end else if (clk_enable && load_fd && instr_count != '1) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`else
  logic unused_load_fd;
  assign unused_load_fd = load_fd;
`endif

endmodule
